fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of FIFO read data and stream data.
REQ-002 Parameter PKT_LEN, default 16, beats per packet; legal range 1..65535.
REQ-003 rclk  input  1  single clock for the whole block; all flops rise-edge on rclk.
REQ-004 rrst  input  1  reset; asynchronous assert, active-high.
REQ-005 fifo_empty  input  1  empty flag from the async FIFO read side.
REQ-006 fifo_data  input  DATA_WIDTH  FIFO read data; valid one rclk cycle after fifo_r_en is sampled high with fifo_empty low.
REQ-007 fifo_r_en  output  1  FIFO read enable.
REQ-008 m_valid  output  1  stream beat valid.
REQ-009 m_ready  input  1  downstream accepts beat.
REQ-010 m_data  output  DATA_WIDTH  stream beat data.
REQ-011 m_last  output  1  final beat of the current packet.
REQ-012 pkt_count  output  16  number of completed packets, modulo 2^16.

Function
REQ-013 The block SHALL hold a 2-entry in-order output buffer; occupancy occ takes states EMPTY(0), ONE(1) and TWO(2).
REQ-014 The block SHALL keep inflight = 1 for the cycle after a read issue (fifo_r_en high and fifo_empty low), else 0.
REQ-015 pop SHALL equal m_valid AND m_ready.
REQ-016 fifo_r_en SHALL be combinational: NOT rrst AND NOT fifo_empty AND (occ + inflight - pop) < 2.
REQ-017 Whenever inflight = 1, fifo_data SHALL be written into the buffer tail on that rclk edge.
REQ-018 occ transitions: +1 on capture only; -1 on pop only; unchanged on capture and pop together, or on neither.
REQ-019 Capture with occ = TWO and no pop SHALL be impossible by REQ-016; the verification bench treats it as an assertion failure.
REQ-020 m_valid SHALL equal (occ != EMPTY); m_data SHALL be the buffer head entry.
REQ-021 A beat, once presented, SHALL hold m_valid, m_data and m_last stable until it is popped.
REQ-022 With m_ready held high and the FIFO never empty, the block SHALL pop one beat per cycle after the first beat (full throughput).
REQ-023 Latency: first fifo_r_en issue at cycle N gives capture at N+1 and m_valid high from N+1 (head visible after that edge).
REQ-024 A beat counter beat_idx (0..PKT_LEN-1) SHALL increment on each pop and wrap to 0 on the pop where m_last is high.
REQ-025 m_last SHALL equal m_valid AND (beat_idx == PKT_LEN-1); with PKT_LEN = 1, every beat is last.
REQ-026 pkt_count SHALL increment by 1 on each pop with m_last high, wrapping from 65535 to 0.
REQ-027 fifo_empty going high while inflight = 1 SHALL NOT cancel the pending capture.
REQ-028 m_ready low with occ = TWO SHALL hold fifo_r_en low.

Reset
REQ-029 While rrst is high: occ = EMPTY, inflight = 0, beat_idx = 0, pkt_count = 0, fifo_r_en = 0, m_valid = 0, m_last = 0, m_data = 0.
REQ-030 rrst asserted mid-operation SHALL clear state immediately; buffered beats and any in-flight FIFO word are discarded and never presented.
REQ-031 After rrst deasserts, the first fifo_r_en SHALL be no earlier than the first rclk edge with rrst sampled low.

Verification
REQ-032 Reset: hold rrst high with fifo_empty = 0 -> fifo_r_en = 0, m_valid = 0, pkt_count = 0 throughout.
REQ-033 Streaming: 32 words 0x00..0x1F, m_ready = 1, PKT_LEN = 16 -> 32 beats in order, m_last on beats 0x0F and 0x1F, pkt_count = 2, no bubble after the first beat.
REQ-034 Backpressure: m_ready = 0 for 10 cycles mid-stream -> occ reaches TWO, fifo_r_en low, m_data stable; no data loss or duplication on release.
REQ-035 Empty toggling: fifo_empty randomly high about 50% of cycles -> output order preserved, every fifo_r_en issue captured exactly once.
REQ-036 Reset mid-packet: rrst pulse after beat 5 of a packet -> outputs cleared; the next beat has beat_idx 0 and pkt_count restarts at 0.
REQ-037 Wrap: PKT_LEN = 1, 65537 beats -> pkt_count wraps to 1, and m_last is high on every beat.

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// Output stream bundle of fifo_rd_stream.
// Master drives the beat, slave drives ready.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Async-FIFO read side to valid/ready packet stream.
// Two-entry skid buffer, one beat per cycle, packet framing.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  fifo_rd_stream_if.master      m,
  output logic [15:0]           pkt_count
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  occ_e                  occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [15:0]           beat_idx_q, beat_idx_d;
  logic [15:0]           pkt_q, pkt_d;

  logic       valid;
  logic       last;
  logic       pop;
  logic       cap;
  logic [2:0] need;

  assign valid = (occ_q != OCC_EMPTY);
  assign last  = valid && (beat_idx_q == LAST_IDX);
  assign pop   = valid && m.m_ready;
  assign cap   = inflight_q;

  assign m.m_valid = valid;
  assign m.m_data  = head_q;
  assign m.m_last  = last;
  assign pkt_count = pkt_q;

  // Slots committed next cycle; only read when one is guaranteed free.
  assign need = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};

  assign fifo_r_en = !rrst && !fifo_empty && (need < 3'd2);

  // Occupancy FSM and in-order buffer update.
  always_comb begin
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = fifo_r_en;
    unique case (1'b1)
      (cap && !pop): begin
        if (occ_q == OCC_EMPTY) begin
          occ_d  = OCC_ONE;
          head_d = fifo_data;
        end else begin
          occ_d  = OCC_TWO;
          tail_d = fifo_data;
        end
      end
      (!cap && pop): begin
        head_d = tail_q;
        occ_d  = (occ_q == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
      end
      (cap && pop): begin
        if (occ_q == OCC_TWO) begin
          head_d = tail_q;
          tail_d = fifo_data;
        end else begin
          head_d = fifo_data;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Packet framing: beat index and completed-packet count.
  always_comb begin
    beat_idx_d = beat_idx_q;
    pkt_d      = pkt_q;
    if (pop) begin
      if (last) begin
        beat_idx_d = 16'd0;
        pkt_d      = pkt_q + 16'd1;
      end else begin
        beat_idx_d = beat_idx_q + 16'd1;
      end
    end
  end

  // State registers; reset drops buffered and in-flight words.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      occ_q      <= OCC_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      beat_idx_q <= 16'd0;
      pkt_q      <= 16'd0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_idx_q <= beat_idx_d;
      pkt_q      <= pkt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream.
// DUT a: PKT_LEN 16 directed cases; DUT b: PKT_LEN 1 wrap.
module tb_fifo_rd_stream;

  localparam int DW = 8;

  logic rclk = 1'b0;
  logic rrst = 1'b1;
  always #5 rclk = ~rclk;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) ma ();
  fifo_rd_stream_if #(.DATA_WIDTH(DW)) mb ();

  logic          fifo_empty_a;
  logic          fifo_r_en_a;
  logic [DW-1:0] fifo_data_a = '0;
  logic [15:0]   pkt_a;

  logic          fifo_empty_b;
  logic          fifo_r_en_b;
  logic [DW-1:0] fifo_data_b = '0;
  logic [15:0]   pkt_b;

  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(16)) dut_a (
    .rclk       (rclk),
    .rrst       (rrst),
    .fifo_empty (fifo_empty_a),
    .fifo_data  (fifo_data_a),
    .fifo_r_en  (fifo_r_en_a),
    .m          (ma),
    .pkt_count  (pkt_a)
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(1)) dut_b (
    .rclk       (rclk),
    .rrst       (rrst),
    .fifo_empty (fifo_empty_b),
    .fifo_data  (fifo_data_b),
    .fifo_r_en  (fifo_r_en_b),
    .m          (mb),
    .pkt_count  (pkt_b)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] qb[$];

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] src_mem [256];
  int  src_wr = 0;
  int  src_rd = 0;
  int  issued_a = 0;
  int  pops_a = 0;
  int  disc_a = 0;
  int  last_pop_cyc = 0;
  int  sb_idx = 0;
  bit  gate_a = 1'b0;

  bit  b_run = 1'b0;
  int  issued_b = 0;
  int  pops_b = 0;

  assign fifo_empty_a = gate_a || (src_rd == src_wr);
  assign fifo_empty_b = !b_run || (issued_b >= 65537);

  always @(posedge rclk) cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic load_a(logic [7:0] w);
    beat_t b;
    src_mem[src_wr[7:0]] = w;
    src_wr++;
    b.d = w;
    b.l = (sb_idx == 15);
    exp_q.push_back(b);
    sb_idx = (sb_idx == 15) ? 0 : sb_idx + 1;
  endtask

  task automatic wait_pops(int target, int budget, string nm);
    int k = 0;
    do begin
      @(posedge rclk);
      k++;
    end while (pops_a < target && k < budget);
    check(nm, 32'(pops_a), 32'(target));
  endtask

  // FIFO model for dut a: data valid one cycle after a read.
  always @(posedge rclk) begin
    if (fifo_r_en_a && !fifo_empty_a) begin
      fifo_data_a <= src_mem[src_rd[7:0]];
      src_rd      <= src_rd + 1;
      issued_a    <= issued_a + 1;
    end
  end

  // FIFO model for dut b: running counter, expectation pushed on issue.
  always @(posedge rclk) begin
    if (fifo_r_en_b && !fifo_empty_b) begin
      fifo_data_b <= issued_b[7:0];
      qb.push_back(issued_b[7:0]);
      issued_b    <= issued_b + 1;
    end
  end

  // Monitor a: pops, hold stability, occupancy bound.
  initial begin
    beat_t      e;
    bit         held;
    logic [7:0] hold_d;
    logic       hold_l;
    int         occ_now;
    held = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    forever begin
      @(negedge rclk);
      if (rrst) begin
        held   = 1'b0;
        disc_a = issued_a - pops_a;
      end else begin
        if (!b_run) begin
          occ_now = issued_a - pops_a - disc_a;
          check("a_occ_max", 32'(occ_now <= 2), 32'd1);
        end
        if (held) begin
          check("a_hold_valid", 32'(ma.m_valid), 32'd1);
          check("a_hold_data", 32'(ma.m_data), 32'(hold_d));
          check("a_hold_last", 32'(ma.m_last), 32'(hold_l));
        end
        if (ma.m_valid && ma.m_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL a_extra_beat: got 0x%0h expected none at %0t",
                     ma.m_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("a_data", 32'(ma.m_data), 32'(e.d));
            check("a_last", 32'(ma.m_last), 32'(e.l));
          end
          pops_a++;
          last_pop_cyc = cyc;
        end
        held   = ma.m_valid && !ma.m_ready;
        hold_d = ma.m_data;
        hold_l = ma.m_last;
      end
    end
  end

  // Monitor b: every beat is last, data in issue order.
  initial begin
    logic [7:0] eb;
    forever begin
      @(negedge rclk);
      if (!rrst && mb.m_valid && mb.m_ready) begin
        if (qb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL b_extra_beat: got 0x%0h expected none at %0t",
                   mb.m_data, $time);
        end else begin
          eb = qb.pop_front();
          check("b_data", 32'(mb.m_data), 32'(eb));
          check("b_last", 32'(mb.m_last), 32'd1);
        end
        pops_b++;
      end
    end
  end

  initial begin
    int t1;
    int t2;
    int k;
    ma.m_ready = 1'b1;
    mb.m_ready = 1'b1;

    // Reset held with FIFO non-empty
    for (int i = 0; i < 32; i++) load_a(8'(i));
    repeat (5) begin
      @(negedge rclk);
      check("rst_r_en", 32'(fifo_r_en_a), 32'd0);
      check("rst_valid", 32'(ma.m_valid), 32'd0);
      check("rst_last", 32'(ma.m_last), 32'd0);
      check("rst_data", 32'(ma.m_data), 32'd0);
      check("rst_pkt", 32'(pkt_a), 32'd0);
    end
    check("rst_pkt_b", 32'(pkt_b), 32'd0);
    #1 rrst = 1'b0;
    #1 check("lat_r_en", 32'(fifo_r_en_a), 32'd1);
    @(negedge rclk);
    check("lat_valid_n", 32'(ma.m_valid), 32'd0);
    @(negedge rclk);
    check("lat_valid_n1", 32'(ma.m_valid), 32'd1);
    check("lat_data", 32'(ma.m_data), 32'h00);

    // Streaming, full throughput
    wait_pops(1, 20, "stream_first");
    t1 = last_pop_cyc;
    wait_pops(32, 100, "stream_done");
    t2 = last_pop_cyc;
    check("stream_no_bubble", 32'(t2 - t1), 32'd31);
    #1 check("stream_pkt", 32'(pkt_a), 32'd2);

    // Backpressure mid-stream
    for (int i = 0; i < 20; i++) load_a(8'(8'h40 + i));
    wait_pops(35, 50, "bp_pre");
    #1 ma.m_ready = 1'b0;
    repeat (10) @(posedge rclk);
    #1;
    check("bp_r_en", 32'(fifo_r_en_a), 32'd0);
    check("bp_valid", 32'(ma.m_valid), 32'd1);
    check("bp_occ_two", 32'(issued_a - pops_a - disc_a), 32'd2);
    ma.m_ready = 1'b1;
    wait_pops(52, 100, "bp_done");
    #1 check("bp_pkt", 32'(pkt_a), 32'd3);

    // Empty flag toggling
    for (int i = 0; i < 12; i++) load_a(8'(8'h60 + i));
    k = 0;
    while (pops_a < 64 && k < 500) begin
      @(posedge rclk);
      #1 gate_a = 1'($urandom_range(0, 1));
      k++;
    end
    gate_a = 1'b0;
    check("tog_done", 32'(pops_a), 32'd64);
    check("tog_pkt", 32'(pkt_a), 32'd4);

    // Reset mid-packet after beat 5
    for (int i = 0; i < 16; i++) load_a(8'(8'h80 + i));
    wait_pops(70, 50, "mid_pre");
    #1 rrst = 1'b1;
    src_wr = src_rd;
    exp_q.delete();
    sb_idx = 0;
    #1;
    check("mid_valid", 32'(ma.m_valid), 32'd0);
    check("mid_r_en", 32'(fifo_r_en_a), 32'd0);
    check("mid_last", 32'(ma.m_last), 32'd0);
    check("mid_data", 32'(ma.m_data), 32'd0);
    check("mid_pkt", 32'(pkt_a), 32'd0);
    @(posedge rclk);
    #3 rrst = 1'b0;
    for (int i = 0; i < 16; i++) load_a(8'(8'h90 + i));
    wait_pops(86, 100, "mid_done");
    #1 check("mid_pkt_after", 32'(pkt_a), 32'd1);
    check("a_sb_empty", 32'(exp_q.size()), 32'd0);

    // PKT_LEN 1 wrap of pkt_count
    b_run = 1'b1;
    k = 0;
    while (pops_b < 65537 && k < 70000) begin
      @(posedge rclk);
      k++;
    end
    check("wrap_beats", 32'(pops_b), 32'd65537);
    #1 check("wrap_pkt", 32'(pkt_b), 32'd1);
    check("b_sb_empty", 32'(qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
